// File: rtl/msrh_rob_entry_ex_pkg.sv
// Shared types and sizing for one msrh ROB block entry.
// The dispatch width, bus count and ID widths are fixed here so the structs line up everywhere.
package msrh_rob_entry_ex_pkg;

    localparam int DISP_SIZE    = 4;
    localparam int CMT_BUS_SIZE = 4;
    localparam int CMT_ID_W     = 5;
    localparam int RNID_W       = 7;
    localparam int VADDR_W      = 39;
    localparam int CAUSE_W      = 4;

    typedef logic [1:0] rob_state_t;
    localparam rob_state_t IDLE = 2'd0;
    localparam rob_state_t WAIT = 2'd1;
    localparam rob_state_t DONE = 2'd2;

    typedef struct packed {
        logic              valid;
        logic [31:0]       inst;
        logic [RNID_W-1:0] rd_rnid;
    } disp_t;

    typedef struct packed {
        logic                valid;
        logic [CMT_ID_W-1:0] cmt_id;
        logic [DISP_SIZE-1:0] grp_id;
        logic                except_valid;
        logic [CAUSE_W-1:0]  except_type;
        logic [VADDR_W-1:0]  except_tval;
    } done_rpt_t;

    typedef struct packed {
        logic [VADDR_W-1:1]                 pc_addr;
        disp_t [DISP_SIZE-1:0]              inst;
        logic [DISP_SIZE-1:0]               grp_id;
        logic [DISP_SIZE-1:0]               old_rd_valid;
        logic [DISP_SIZE-1:0][RNID_W-1:0]   old_rd_rnid;
        logic [DISP_SIZE-1:0]               done_grp_id;
        logic                               except_valid;
        logic [DISP_SIZE-1:0]               except_grp_id;
        logic [CAUSE_W-1:0]                 except_type;
        logic [VADDR_W-1:0]                 except_tval;
    } rob_entry_t;

    // Bits [k:0] set for a one-hot slot k; a top-slot one-hot wraps to all ones.
    function automatic logic [DISP_SIZE-1:0] upto_mask(input logic [DISP_SIZE-1:0] onehot);
        return (onehot << 1) - DISP_SIZE'(1);
    endfunction

endpackage

// File: rtl/msrh_rob_entry_ex_if.sv
// Load / done-report / commit bundle between the ROB control and one block entry.
interface msrh_rob_entry_ex_if;
    import msrh_rob_entry_ex_pkg::*;

    logic                              i_load_valid;
    logic [VADDR_W-1:1]                i_load_pc_addr;
    disp_t [DISP_SIZE-1:0]             i_load_inst;
    logic [DISP_SIZE-1:0]              i_load_grp_id;
    logic [DISP_SIZE-1:0]              i_old_rd_valid;
    logic [DISP_SIZE-1:0][RNID_W-1:0]  i_old_rd_rnid;
    done_rpt_t [CMT_BUS_SIZE-1:0]      i_done_rpt;
    logic                              i_commit_finish;
    logic                              i_kill;

    logic                              o_valid;
    logic                              o_block_all_done;
    logic [DISP_SIZE-1:0]              o_block_grp_id;
    logic [DISP_SIZE-1:0]              o_live_grp_id;
    logic                              o_except_valid;
    logic [DISP_SIZE-1:0]              o_except_grp_id;
    logic [CAUSE_W-1:0]                o_except_type;
    logic [VADDR_W-1:0]                o_except_tval;

    modport master (
        output i_load_valid, i_load_pc_addr, i_load_inst, i_load_grp_id,
               i_old_rd_valid, i_old_rd_rnid, i_done_rpt, i_commit_finish, i_kill,
        input  o_valid, o_block_all_done, o_block_grp_id, o_live_grp_id,
               o_except_valid, o_except_grp_id, o_except_type, o_except_tval
    );

    modport slave (
        input  i_load_valid, i_load_pc_addr, i_load_inst, i_load_grp_id,
               i_old_rd_valid, i_old_rd_rnid, i_done_rpt, i_commit_finish, i_kill,
        output o_valid, o_block_all_done, o_block_grp_id, o_live_grp_id,
               o_except_valid, o_except_grp_id, o_except_type, o_except_tval
    );

endinterface

// File: rtl/msrh_rob_entry_ex_except_sel.sv
// Picks the oldest (lowest-slot) exception among this cycle's matched done reports.
module msrh_rob_entry_ex_except_sel
    import msrh_rob_entry_ex_pkg::*;
(
    input  logic [DISP_SIZE-1:0]               slot_exc,
    input  logic [DISP_SIZE-1:0][CAUSE_W-1:0]  slot_type,
    input  logic [DISP_SIZE-1:0][VADDR_W-1:0]  slot_tval,
    output logic                               sel_valid,
    output logic [DISP_SIZE-1:0]               sel_grp_id,
    output logic [CAUSE_W-1:0]                 sel_type,
    output logic [VADDR_W-1:0]                 sel_tval
);

    assign sel_valid = |slot_exc;

    // Scan from the top slot down so the lowest excepting slot is written last.
    always_comb begin
        sel_grp_id = '0;
        sel_type   = '0;
        sel_tval   = '0;
        for (int d = DISP_SIZE - 1; d >= 0; d--) begin
            if (slot_exc[d]) begin
                sel_grp_id    = '0;
                sel_grp_id[d] = 1'b1;
                sel_type      = slot_type[d];
                sel_tval      = slot_tval[d];
            end
        end
    end

endmodule

// File: rtl/msrh_rob_entry_ex.sv
// One ROB block entry: holds a dispatch group, collects done reports and keeps the oldest exception.
module msrh_rob_entry_ex
    import msrh_rob_entry_ex_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [CMT_ID_W-1:0]  i_cmt_id,
    msrh_rob_entry_ex_if.slave   rob_if
);

    rob_state_t  state_q;
    rob_entry_t  entry_q;
    rob_entry_t  load_entry;

    logic [DISP_SIZE-1:0]               slot_hit;
    logic [DISP_SIZE-1:0]               slot_exc;
    logic [DISP_SIZE-1:0][CAUSE_W-1:0]  slot_type;
    logic [DISP_SIZE-1:0][VADDR_W-1:0]  slot_tval;

    logic                  sel_valid;
    logic [DISP_SIZE-1:0]  sel_grp_id;
    logic [CAUSE_W-1:0]    sel_type;
    logic [VADDR_W-1:0]    sel_tval;

    logic                  take_exc;
    logic [DISP_SIZE-1:0]  nxt_done;
    logic [DISP_SIZE-1:0]  nxt_exc_grp;
    logic [DISP_SIZE-1:0]  nxt_live;
    logic                  nxt_all_done;
    logic [DISP_SIZE-1:0]  live_q;

    // Per-slot report match; descending bus scan leaves the lowest bus's cause in place.
    always_comb begin
        slot_hit  = '0;
        slot_exc  = '0;
        slot_type = '0;
        slot_tval = '0;
        for (int d = 0; d < DISP_SIZE; d++) begin
            for (int c = CMT_BUS_SIZE - 1; c >= 0; c--) begin
                if (rob_if.i_done_rpt[c].valid &&
                    (rob_if.i_done_rpt[c].cmt_id == i_cmt_id) &&
                    (rob_if.i_done_rpt[c].grp_id == (DISP_SIZE'(1) << d))) begin
                    slot_hit[d] = 1'b1;
                    if (rob_if.i_done_rpt[c].except_valid) begin
                        slot_exc[d]  = 1'b1;
                        slot_type[d] = rob_if.i_done_rpt[c].except_type;
                        slot_tval[d] = rob_if.i_done_rpt[c].except_tval;
                    end
                end
            end
        end
    end

    msrh_rob_entry_ex_except_sel u_except_sel (
        .slot_exc   (slot_exc),
        .slot_type  (slot_type),
        .slot_tval  (slot_tval),
        .sel_valid  (sel_valid),
        .sel_grp_id (sel_grp_id),
        .sel_type   (sel_type),
        .sel_tval   (sel_tval)
    );

    // One-hot compare: a smaller value is an older slot.
    always_comb begin
        take_exc     = sel_valid && (!entry_q.except_valid || (sel_grp_id < entry_q.except_grp_id));
        nxt_done     = entry_q.done_grp_id | slot_hit;
        nxt_exc_grp  = take_exc ? sel_grp_id : entry_q.except_grp_id;
        nxt_live     = (entry_q.except_valid || take_exc) ?
                       (entry_q.grp_id & upto_mask(nxt_exc_grp)) : entry_q.grp_id;
        nxt_all_done = ((nxt_done & nxt_live) == nxt_live);
    end

    always_comb begin
        load_entry              = '0;
        load_entry.pc_addr      = rob_if.i_load_pc_addr;
        load_entry.inst         = rob_if.i_load_inst;
        load_entry.grp_id       = rob_if.i_load_grp_id;
        load_entry.old_rd_valid = rob_if.i_old_rd_valid;
        load_entry.old_rd_rnid  = rob_if.i_old_rd_rnid;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || rob_if.i_kill) begin
            state_q <= IDLE;
            entry_q <= '0;
        end else if (rob_if.i_load_valid) begin
            state_q <= WAIT;
            entry_q <= load_entry;
        end else if ((state_q == DONE) && rob_if.i_commit_finish) begin
            state_q <= IDLE;
            entry_q <= '0;
        end else if (state_q != IDLE) begin
            state_q             <= nxt_all_done ? DONE : WAIT;
            entry_q.done_grp_id <= nxt_done;
            if (take_exc) begin
                entry_q.except_valid  <= 1'b1;
                entry_q.except_grp_id <= sel_grp_id;
                entry_q.except_type   <= sel_type;
                entry_q.except_tval   <= sel_tval;
            end
        end
    end

    assign live_q = entry_q.except_valid ?
                    (entry_q.grp_id & upto_mask(entry_q.except_grp_id)) : entry_q.grp_id;

    assign rob_if.o_valid          = (state_q != IDLE);
    assign rob_if.o_block_all_done = (state_q == DONE);
    assign rob_if.o_block_grp_id   = entry_q.grp_id;
    assign rob_if.o_live_grp_id    = live_q;
    assign rob_if.o_except_valid   = entry_q.except_valid;
    assign rob_if.o_except_grp_id  = entry_q.except_grp_id;
    assign rob_if.o_except_type    = entry_q.except_type;
    assign rob_if.o_except_tval    = entry_q.except_tval;

    // Group payload is held for the commit stage's readout path, not routed out of this slice.
    logic unused_payload;
    assign unused_payload = ^{entry_q.pc_addr, entry_q.inst, entry_q.old_rd_valid, entry_q.old_rd_rnid};

endmodule

// File: tb/tb_msrh_rob_entry_ex.sv
// Directed bench for msrh_rob_entry_ex: stimulus queues expected outputs, a monitor checks them.
module tb_msrh_rob_entry_ex;
    import msrh_rob_entry_ex_pkg::*;

    localparam int OBS_W = 3 + 3 * DISP_SIZE + CAUSE_W + VADDR_W;
    localparam logic [CMT_ID_W-1:0] MY_ID = 5'd3;
    typedef logic [OBS_W-1:0] obs_t;

    logic                 i_clk = 1'b0;
    logic                 i_reset;
    logic [CMT_ID_W-1:0]  i_cmt_id;

    msrh_rob_entry_ex_if rif ();

    msrh_rob_entry_ex dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_cmt_id (i_cmt_id),
        .rob_if   (rif)
    );

    always #5 i_clk = ~i_clk;

    obs_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic obs_t pack(input logic v, input logic ad, input logic [3:0] grp,
                                  input logic [3:0] live, input logic ev, input logic [3:0] eg,
                                  input logic [3:0] et, input logic [VADDR_W-1:0] tv);
        return {v, ad, grp, live, ev, eg, et, tv};
    endfunction

    function automatic obs_t observe();
        return {rif.o_valid, rif.o_block_all_done, rif.o_block_grp_id, rif.o_live_grp_id,
                rif.o_except_valid, rif.o_except_grp_id, rif.o_except_type, rif.o_except_tval};
    endfunction

    task automatic clear_in();
        rif.i_load_valid    = 1'b0;
        rif.i_load_pc_addr  = '0;
        rif.i_load_inst     = '0;
        rif.i_load_grp_id   = '0;
        rif.i_old_rd_valid  = '0;
        rif.i_old_rd_rnid   = '0;
        rif.i_done_rpt      = '0;
        rif.i_commit_finish = 1'b0;
        rif.i_kill          = 1'b0;
    endtask

    task automatic load(input logic [DISP_SIZE-1:0] grp);
        rif.i_load_valid   = 1'b1;
        rif.i_load_pc_addr = 38'h12_3456_7890;
        rif.i_load_grp_id  = grp;
        rif.i_old_rd_valid = grp;
        for (int d = 0; d < DISP_SIZE; d++) begin
            rif.i_load_inst[d].valid   = grp[d];
            rif.i_load_inst[d].inst    = 32'h0000_0013 + 32'(d);
            rif.i_load_inst[d].rd_rnid = RNID_W'(d + 8);
            rif.i_old_rd_rnid[d]       = RNID_W'(d + 1);
        end
    endtask

    task automatic rpt(input int bus, input int slot, input logic [CMT_ID_W-1:0] id,
                       input logic exc, input logic [CAUSE_W-1:0] ty, input logic [VADDR_W-1:0] tv);
        done_rpt_t r;
        r.valid        = 1'b1;
        r.cmt_id       = id;
        r.grp_id       = DISP_SIZE'(1) << slot;
        r.except_valid = exc;
        r.except_type  = ty;
        r.except_tval  = tv;
        rif.i_done_rpt[bus] = r;
    endtask

    // Inputs are driven at the falling edge; the expectation describes outputs after the next rising edge.
    task automatic step(input string nm, input obs_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge i_clk);
        clear_in();
    endtask

    always begin
        @(posedge i_clk);
        #1;
        if (exp_q.size() > 0) begin
            obs_t  e;
            obs_t  a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = observe();
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", nm, a, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        obs_t z;
        z = pack(0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 4'h0, '0);
        i_cmt_id = MY_ID;
        i_reset  = 1'b1;
        clear_in();
        @(negedge i_clk);

        step("reset0", z);
        step("reset1", z);
        i_reset = 1'b0;

        // Three slots completing one per cycle, then commit.
        load(4'b0111);                     step("t1_load",   pack(1, 0, 4'b0111, 4'b0111, 0, 4'b0000, 4'h0, '0));
        rpt(0, 0, MY_ID, 0, 0, 0);         step("t1_slot0",  pack(1, 0, 4'b0111, 4'b0111, 0, 4'b0000, 4'h0, '0));
        rpt(1, 1, MY_ID, 0, 0, 0);         step("t1_slot1",  pack(1, 0, 4'b0111, 4'b0111, 0, 4'b0000, 4'h0, '0));
        rpt(2, 2, MY_ID, 0, 0, 0);         step("t1_slot2",  pack(1, 1, 4'b0111, 4'b0111, 0, 4'b0000, 4'h0, '0));
        rif.i_commit_finish = 1'b1;        step("t1_commit", z);

        // Slot-1 exception kills slots 2-3; slot 0 finishing completes the group.
        load(4'b1111);                     step("t2_load",   pack(1, 0, 4'b1111, 4'b1111, 0, 4'b0000, 4'h0, '0));
        rpt(1, 1, MY_ID, 1, 4'd2, 39'h100); step("t2_exc1",  pack(1, 0, 4'b1111, 4'b0011, 1, 4'b0010, 4'h2, 39'h100));
        rpt(2, 0, MY_ID, 0, 0, 0);         step("t2_done",   pack(1, 1, 4'b1111, 4'b0011, 1, 4'b0010, 4'h2, 39'h100));
                                           step("t2_hold",   pack(1, 1, 4'b1111, 4'b0011, 1, 4'b0010, 4'h2, 39'h100));
        rif.i_commit_finish = 1'b1;        step("t2_commit", z);

        // Same-cycle exceptions: lowest slot wins regardless of bus; younger later ones ignored; older one moves capture.
        load(4'b1111);                     step("t3_load",   pack(1, 0, 4'b1111, 4'b1111, 0, 4'b0000, 4'h0, '0));
        rpt(0, 2, MY_ID, 1, 4'd5, 39'h222);
        rpt(3, 1, MY_ID, 1, 4'd7, 39'h333); step("t3_lowslot", pack(1, 0, 4'b1111, 4'b0011, 1, 4'b0010, 4'h7, 39'h333));
        rpt(0, 3, MY_ID, 1, 4'd4, 39'h777); step("t3_younger", pack(1, 0, 4'b1111, 4'b0011, 1, 4'b0010, 4'h7, 39'h333));
        rpt(2, 0, MY_ID, 1, 4'd1, 39'h444); step("t3_move0",   pack(1, 1, 4'b1111, 4'b0001, 1, 4'b0001, 4'h1, 39'h444));
        rif.i_commit_finish = 1'b1;        step("t3_commit", z);

        // Equal slot on two buses: lower bus index supplies the cause; then kill mid-wait.
        load(4'b0011);                     step("t4_load",   pack(1, 0, 4'b0011, 4'b0011, 0, 4'b0000, 4'h0, '0));
        rpt(2, 1, MY_ID, 1, 4'hB, 39'h555);
        rpt(1, 1, MY_ID, 1, 4'hC, 39'h666); step("t4_tie",   pack(1, 0, 4'b0011, 4'b0011, 1, 4'b0010, 4'hC, 39'h666));
        rif.i_kill = 1'b1;                 step("t4_kill",   z);

        // Report in the load cycle and a foreign cmt_id are both dropped; early commit ignored.
        load(4'b0001);
        rpt(0, 0, MY_ID, 0, 0, 0);         step("t5_load_rpt", pack(1, 0, 4'b0001, 4'b0001, 0, 4'b0000, 4'h0, '0));
        rpt(0, 0, 5'd4, 0, 0, 0);          step("t5_bad_id",   pack(1, 0, 4'b0001, 4'b0001, 0, 4'b0000, 4'h0, '0));
        rif.i_commit_finish = 1'b1;        step("t5_early_cmt", pack(1, 0, 4'b0001, 4'b0001, 0, 4'b0000, 4'h0, '0));
        rpt(3, 0, MY_ID, 0, 0, 0);         step("t5_done",     pack(1, 1, 4'b0001, 4'b0001, 0, 4'b0000, 4'h0, '0));
        load(4'b0011);
        rif.i_commit_finish = 1'b1;        step("t5_load_cmt", pack(1, 0, 4'b0011, 4'b0011, 0, 4'b0000, 4'h0, '0));
        rpt(0, 0, MY_ID, 0, 0, 0);         step("t5_partial",  pack(1, 0, 4'b0011, 4'b0011, 0, 4'b0000, 4'h0, '0));

        // Reset mid-wait, then kill while idle.
        i_reset = 1'b1;                    step("t6_reset",     z);
        i_reset = 1'b0;
        rif.i_kill = 1'b1;                 step("t6_kill_idle", z);

        @(negedge i_clk);
        @(negedge i_clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
